// File: rtl/ntt_bitrev_loader.sv
// Ping-pong loader: scatters natural-order coefficients into bit-reversed frames for the butterfly network.
// Optional per-word conditional modular reduction: define NTT_BITREV_LOADER_MOD_REDUCE_EN.
module ntt_bitrev_loader #(
   parameter int DATA_W = 8,
   parameter int N      = 8,
   localparam int LOG_N = $clog2(N)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [DATA_W-1:0]   mod,
   input  logic [DATA_W-1:0]   in_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [N*DATA_W-1:0] out_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [LOG_N-1:0]    wr_index
);

   logic [DATA_W-1:0] bank [2][N];
   logic [1:0]        full;
   logic              wr_bank;
   logic              rd_bank;
   logic [LOG_N-1:0]  wr_idx;
   logic [DATA_W-1:0] store_data;
   logic              accept;
   logic              release_frame;
   logic              frame_done;

   function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] x);
      return {<<{x}};
   endfunction

   assign in_ready      = !full[wr_bank] && !rst;
   assign out_valid     = full[rd_bank];
   assign accept        = in_valid && in_ready;
   assign release_frame = out_valid && out_ready;
   assign frame_done    = accept && (wr_idx == LOG_N'(N-1));
   assign wr_index      = wr_idx;

`ifdef NTT_BITREV_LOADER_MOD_REDUCE_EN
   always_comb begin
      store_data = (in_data >= mod) ? in_data - mod : in_data;
   end
`else
   logic unused_mod;
   assign unused_mod = ^mod;

   always_comb begin
      store_data = in_data;
   end
`endif

   for (genvar k = 0; k < N; k++) begin : g_out
      assign out_data[k*DATA_W +: DATA_W] = bank[rd_bank][k];
   end

   // Full flags gate both sides, so the accept and release never target the same bank.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_idx  <= '0;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         full    <= '0;
         bank    <= '{default: '0};
      end else begin
         if (accept) begin
            bank[wr_bank][bitrev(wr_idx)] <= store_data;
            wr_idx <= frame_done ? '0 : wr_idx + LOG_N'(1);
            if (frame_done) begin
               full[wr_bank] <= 1'b1;
               wr_bank       <= !wr_bank;
            end
         end
         if (release_frame) begin
            full[rd_bank] <= 1'b0;
            rd_bank       <= !rd_bank;
         end
      end
   end

endmodule
